// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select lines of a shared 4:1 mux.
// The owner-release input is named release_grant because "release" is a reserved word.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       release_grant,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy,
    output logic       timeout
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic             state, state_nxt;
    logic [1:0]       last, last_nxt;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
    logic [3:0]       gnt_nxt;
    logic [1:0]       sel, sel_nxt;
    logic             busy_nxt;
    logic             timeout_nxt;

    logic             pick_found;
    logic [1:0]       pick_idx;
    logic [1:0]       cand;
    logic             expire;
    logic             owner_req;
    logic             grant_end;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            last     <= 2'd3;
            hold_cnt <= '0;
            gnt      <= 4'b0000;
            sel      <= 2'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_cnt_nxt;
            gnt      <= gnt_nxt;
            sel      <= sel_nxt;
            busy     <= busy_nxt;
            timeout  <= timeout_nxt;
        end
    end

    // Round-robin search from last+1 wrapping to last; the current owner is
    // therefore only chosen again when it is the sole requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last;
        cand       = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state and output logic; in GRANT, last always holds the owner index
    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        hold_cnt_nxt = hold_cnt;
        gnt_nxt      = gnt;
        sel_nxt      = sel;
        busy_nxt     = busy;
        timeout_nxt  = 1'b0;
        owner_req    = req[last];
        expire       = (hold_cnt == HOLD_LAST);
        grant_end    = release_grant || !owner_req || expire;

        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_nxt    = ST_GRANT;
                    last_nxt     = pick_idx;
                    hold_cnt_nxt = '0;
                    gnt_nxt      = 4'b0001 << pick_idx;
                    sel_nxt      = pick_idx;
                    busy_nxt     = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!grant_end) begin
                    hold_cnt_nxt = hold_cnt + CNT_W'(1);
                end else if (pick_found) begin
                    last_nxt     = pick_idx;
                    hold_cnt_nxt = '0;
                    gnt_nxt      = 4'b0001 << pick_idx;
                    sel_nxt      = pick_idx;
                    busy_nxt     = 1'b1;
                    timeout_nxt  = expire && !release_grant && owner_req;
                end else begin
                    // Select lines keep the last index so the mux output stays stable
                    state_nxt    = ST_IDLE;
                    hold_cnt_nxt = '0;
                    gnt_nxt      = 4'b0000;
                    busy_nxt     = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign s0 = sel[0];
    assign s1 = sel[1];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed vector table, multi-cycle sequences,
// and random traffic against a cycle-level behavioural model.
module tb_mux4_rr_arbiter;

    localparam int unsigned MAX_HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       release_grant;
    logic [3:0] gnt;
    logic       s0, s1, busy, timeout;

    int total  = 0;
    int passed = 0;

    // Model state: owner index (-1 when idle) and cycles the owner has held the grant
    int m_owner = -1;
    int m_last  = 3;
    int m_held  = 0;
    int m_sel   = 0;
    bit m_to    = 1'b0;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       rel;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t vecs[9];

    mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .release_grant(release_grant),
        .gnt          (gnt),
        .s0           (s0),
        .s1           (s1),
        .busy         (busy),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    function automatic int rr_pick(logic [3:0] r, int from_last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from_last + k) % 4]) return (from_last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic rn, input logic [3:0] rq, input logic rl);
        int  w;
        bit  expired;
        if (!rn) begin
            m_owner = -1; m_last = 3; m_held = 0; m_sel = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                w = rr_pick(rq, m_last);
                if (w >= 0) begin
                    m_owner = w; m_last = w; m_held = 1; m_sel = w;
                end
            end else begin
                expired = (m_held >= int'(MAX_HOLD));
                if (rl || !rq[m_owner] || expired) begin
                    m_to = expired && !rl && rq[m_owner];
                    w = rr_pick(rq, m_last);
                    if (w >= 0) begin
                        m_owner = w; m_last = w; m_held = 1; m_sel = w;
                    end else begin
                        m_owner = -1;
                    end
                end else begin
                    m_held++;
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic b, input logic t);
        chk({tag, ".gnt"}, gnt, g);
        chk({tag, ".sel"}, {2'b00, s1, s0}, {2'b00, s});
        chk({tag, ".busy"}, {3'b000, busy}, {3'b000, b});
        chk({tag, ".timeout"}, {3'b000, timeout}, {3'b000, t});
    endtask

    // Drive inputs (called just after a negedge), clock one edge, sample #1 later
    task automatic step(input logic rn, input logic [3:0] rq, input logic rl);
        rst_n = rn; req = rq; release_grant = rl;
        @(posedge clk);
        model_edge(rn, rq, rl);
        #1;
    endtask

    task automatic next_slot();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req = 4'b0000; release_grant = 1'b0;

        vecs[0] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};

        next_slot();

        // Reset, fairness rotation, drop to idle, release ignored in idle
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst_n, vecs[i].req, vecs[i].rel);
            expect_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, vecs[i].to);
            next_slot();
        end

        // Timeout with a contender: 8 cycles of 0001, then 0100 with a timeout pulse
        step(1'b0, 4'b0000, 1'b0);
        next_slot();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b0101, 1'b0);
            expect_out($sformatf("tmo_hold%0d", i), 4'b0001, 2'd0, 1'b1, 1'b0);
            next_slot();
        end
        step(1'b1, 4'b0101, 1'b0);
        expect_out("tmo_switch", 4'b0100, 2'd2, 1'b1, 1'b1);
        next_slot();
        step(1'b1, 4'b0101, 1'b0);
        expect_out("tmo_after", 4'b0100, 2'd2, 1'b1, 1'b0);
        next_slot();
        step(1'b1, 4'b0000, 1'b0);
        expect_out("tmo_idle", 4'b0000, 2'd2, 1'b0, 1'b0);
        next_slot();

        // Solo owner: regranted with a timeout pulse every 8 cycles
        step(1'b1, 4'b0010, 1'b0);
        expect_out("solo_start", 4'b0010, 2'd1, 1'b1, 1'b0);
        next_slot();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 7; i++) begin
                step(1'b1, 4'b0010, 1'b0);
                expect_out($sformatf("solo_r%0d_%0d", r, i), 4'b0010, 2'd1, 1'b1, 1'b0);
                next_slot();
            end
            step(1'b1, 4'b0010, 1'b0);
            expect_out($sformatf("solo_tmo%0d", r), 4'b0010, 2'd1, 1'b1, 1'b1);
            next_slot();
        end
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 4'b0010, 1'b0);
            expect_out($sformatf("solo_last%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
            next_slot();
        end
        // Release and request drop coincide with expiry: no timeout, idle, select held
        step(1'b1, 4'b0000, 1'b1);
        expect_out("solo_coinc", 4'b0000, 2'd1, 1'b0, 1'b0);
        next_slot();

        // Mid-operation reset with grant 1000 at hold count 4
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1000, 1'b0);
            expect_out($sformatf("mid_pre%0d", i), 4'b1000, 2'd3, 1'b1, 1'b0);
            next_slot();
        end
        step(1'b0, 4'b1000, 1'b0);
        expect_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        next_slot();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b1000, 1'b0);
            expect_out($sformatf("mid_post%0d", i), 4'b1000, 2'd3, 1'b1, 1'b0);
            next_slot();
        end
        step(1'b1, 4'b1000, 1'b0);
        expect_out("mid_budget", 4'b1000, 2'd3, 1'b1, 1'b1);
        next_slot();

        // Random traffic against the model
        step(1'b0, 4'b0000, 1'b0);
        next_slot();
        for (int i = 0; i < 3000; i++) begin
            logic       rn;
            logic [3:0] rq;
            logic       rl;
            rn = ($urandom_range(0, 199) != 0);
            rq = ($urandom_range(0, 3) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            rl = ($urandom_range(0, 5) == 0);
            step(rn, rq, rl);
            expect_out($sformatf("rnd%0d", i),
                       (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner),
                       2'(m_sel), (m_owner >= 0), m_to);
            next_slot();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
